// File: rtl/mul4s_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mul4s_rr_arbiter
//  Purpose  : Shares one combinational signed 4x4 multiplier among NUM_REQ
//             requesters. A round-robin arbiter picks one operand pair per
//             cycle. The 8-bit signed product leaves through a registered
//             valid/ready result channel and is tagged with the requester
//             index.
//  Ports    : clk, rst                 clock, synchronous active-high reset
//             req_valid/req_ready      per-requester operand handshake
//             req_a/req_b              packed signed operands, 4 bits each
//             res_valid/res_ready      result handshake
//             res_out/res_id           signed product and requester index
//  Options  : MUL4S_ARB_PIPE_EN adds an operand register stage in front of
//             the multiplier, which makes the latency 2 cycles.
//  Revision : 1.0  initial release
// ============================================================================

// Exact signed 4b x 4b -> 8b multiplier core.
module mul4s_core (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);
    // Both operands are sign-extended to 8 bits so that the multiply is
    // evaluated at the full product width.
    assign o_p = $signed({{4{i_a[3]}}, i_a}) * $signed({{4{i_b[3]}}, i_b});
endmodule

module mul4s_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [4*NUM_REQ-1:0] req_a,
    input  logic [4*NUM_REQ-1:0] req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [7:0]           res_out,
    output logic [ID_W-1:0]      res_id
);

    logic [ID_W-1:0] r_ptr;
    logic            r_res_valid;
    logic [7:0]      r_res_out;
    logic [ID_W-1:0] r_res_id;

    logic            w_found;
    logic [ID_W-1:0] w_gnt_idx;
    logic            w_free;
    logic            w_fire;
    logic [ID_W-1:0] w_ptr_next;
    logic [3:0]      w_gnt_a;
    logic [3:0]      w_gnt_b;
    logic [3:0]      w_core_a;
    logic [3:0]      w_core_b;
    logic [7:0]      w_prod;

    // ------------------------------------------------------------------
    // Round-robin search: first valid requester at or after r_ptr,
    // wrapping modulo NUM_REQ. r_ptr is always below NUM_REQ, so one
    // conditional subtraction is enough to wrap.
    // ------------------------------------------------------------------
    always_comb begin : p_search
        int idx;
        idx       = 0;
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_found && req_valid[idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = ID_W'(idx);
            end
        end
    end

    assign w_fire     = w_found & w_free & ~rst;
    assign w_ptr_next = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_gnt_a    = req_a[4*w_gnt_idx +: 4];
    assign w_gnt_b    = req_b[4*w_gnt_idx +: 4];

    // The grant vector is one-hot, and it is forced to zero during reset.
    always_comb begin
        req_ready = '0;
        if (w_fire) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    mul4s_core u_core (
        .i_a (w_core_a),
        .i_b (w_core_b),
        .o_p (w_prod)
    );

    // Round-robin pointer: it moves only when a grant completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_fire) begin
            r_ptr <= w_ptr_next;
        end
    end

`ifdef MUL4S_ARB_PIPE_EN
    // ------------------------------------------------------------------
    // Two-stage version. Stage 1 holds the granted operands. The result
    // register is loaded from stage 1 through the multiplier.
    // ------------------------------------------------------------------
    logic            r_s1_valid;
    logic [3:0]      r_s1_a;
    logic [3:0]      r_s1_b;
    logic [ID_W-1:0] r_s1_id;
    logic            w_s1_adv;

    assign w_s1_adv = ~r_res_valid | res_ready;
    assign w_free   = ~r_s1_valid | w_s1_adv;
    assign w_core_a = r_s1_a;
    assign w_core_b = r_s1_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_id    <= '0;
        end else if (w_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= w_gnt_a;
            r_s1_b     <= w_gnt_b;
            r_s1_id    <= w_gnt_idx;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_out   <= '0;
            r_res_id    <= '0;
        end else if (w_s1_adv) begin
            if (r_s1_valid) begin
                r_res_valid <= 1'b1;
                r_res_out   <= w_prod;
                r_res_id    <= r_s1_id;
            end else begin
                r_res_valid <= 1'b0;
            end
        end
    end
`else
    // ------------------------------------------------------------------
    // Single-stage version. The product of the granted pair is registered
    // directly. A drain and a new grant in the same cycle replace the
    // held result without a bubble.
    // ------------------------------------------------------------------
    assign w_free   = ~r_res_valid | res_ready;
    assign w_core_a = w_gnt_a;
    assign w_core_b = w_gnt_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_out   <= '0;
            r_res_id    <= '0;
        end else if (w_fire) begin
            r_res_valid <= 1'b1;
            r_res_out   <= w_prod;
            r_res_id    <= w_gnt_idx;
        end else if (res_ready) begin
            r_res_valid <= 1'b0;
        end
    end
`endif

    assign res_valid = r_res_valid;
    assign res_out   = r_res_out;
    assign res_id    = r_res_id;

endmodule
`default_nettype wire

// File: tb/tb_mul4s_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul4s_rr_arbiter
//  Purpose  : Self-checking bench for mul4s_rr_arbiter (single-stage build).
//             Directed scenarios are followed by a randomized phase. Both are
//             checked against a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul4s_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [4*NUM_REQ-1:0] req_a;
    logic [4*NUM_REQ-1:0] req_b;
    logic                 res_valid;
    logic                 res_ready;
    logic [7:0]           res_out;
    logic [ID_W-1:0]      res_id;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state: the held result and the round-robin position.
    logic       m_valid;
    logic [7:0] m_out;
    int         m_id;
    int         m_ptr;
    int         last_g;

    mul4s_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_out   (res_out),
        .res_id    (res_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sval4(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    function automatic logic [7:0] ref_prod(input logic [3:0] a, input logic [3:0] b);
        int p;
        p = sval4(a) * sval4(b);
        return 8'(p & 255);
    endfunction

    // Requester the specification grants this cycle, or -1 if none.
    function automatic int ref_grant();
        if (rst) return -1;
        if (m_valid && !res_ready) return -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_valid[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [3:0] a, input logic [3:0] b);
        req_valid[i]   = v;
        req_a[4*i +: 4] = a;
        req_b[4*i +: 4] = b;
    endtask

    // One clock: check the grant before the edge, advance the model at the
    // edge, then check the registered result just after the edge.
    task automatic cycle();
        int g;
        logic [NUM_REQ-1:0] er;
        #1;
        g  = ref_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_out = 8'h00; m_id = 0; m_ptr = 0;
        end else if (g >= 0) begin
            m_valid = 1'b1;
            m_out   = ref_prod(req_a[4*g +: 4], req_b[4*g +: 4]);
            m_id    = g;
            m_ptr   = (g + 1) % NUM_REQ;
        end else if (res_ready && m_valid) begin
            m_valid = 1'b0;
        end
        last_g = g;
        #1;
        chk("res_valid", 32'(res_valid), 32'(m_valid));
        chk("res_out",   32'(res_out),   32'(m_out));
        chk("res_id",    32'(res_id),    32'(m_id));
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
        m_valid = 1'b0; m_out = '0; m_id = 0; m_ptr = 0; last_g = -1;

        // Reset state
        cycle(); cycle();
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_out",   32'(res_out),   32'd0);
        chk("rst_id",    32'(res_id),    32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;

        // Single requester with corner products
        res_ready = 1'b1;
        set_req(0, 1'b1, 4'h8, 4'h8); cycle();
        chk("m8xm8", 32'(res_out), 32'h40); chk("m8xm8_id", 32'(res_id), 32'd0);
        set_req(0, 1'b1, 4'h8, 4'h7); cycle(); chk("m8x7", 32'(res_out), 32'hC8);
        set_req(0, 1'b1, 4'h7, 4'h7); cycle(); chk("7x7",  32'(res_out), 32'h31);
        set_req(0, 1'b1, 4'h3, 4'hF); cycle(); chk("3xm1", 32'(res_out), 32'hFD);
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                set_req(0, 1'b1, 4'(a), 4'(b));
                cycle();
            end
        end
        set_req(0, 1'b0, 4'h0, 4'h0);

        // Reset so that ptr=0, then all four requesters are valid
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 4'(i + 1), 4'(i + 9));
        for (int j = 0; j < 6; j++) begin
            cycle();
            chk("rr_order", 32'(res_id), 32'(j % NUM_REQ));
            chk("rr_valid", 32'(res_valid), 32'd1);
            chk("onehot", 32'($countones(req_ready)), 32'd1);
        end

        // Only requesters 1 and 3 are valid, and ptr is now 2
        set_req(0, 1'b0, 4'h0, 4'h0); set_req(2, 1'b0, 4'h0, 4'h0);
        cycle(); chk("odd_g3a", 32'(res_id), 32'd3);
        cycle(); chk("odd_g1",  32'(res_id), 32'd1);
        cycle(); chk("odd_g3b", 32'(res_id), 32'd3);

        // Backpressure while all four requesters are valid
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 4'(i + 2), 4'(15 - i));
        res_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            cycle();
            chk("bp_id", 32'(res_id), 32'd3);
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_valid", 32'(res_valid), 32'd1);
        end
        res_ready = 1'b1;
        cycle();
        chk("bp_rel_id", 32'(res_id), 32'd0);
        chk("bp_rel_valid", 32'(res_valid), 32'd1);

        // Drain with no requests; ptr must stay at 1
        req_valid = '0;
        cycle(); chk("drain_valid", 32'(res_valid), 32'd0);
        req_valid = '1;
        cycle(); chk("ptr_hold", 32'(res_id), 32'd1);

        // Reset while a result is pending and all requesters are valid
        rst = 1'b1;
        cycle();
        chk("mrst_valid", 32'(res_valid), 32'd0);
        chk("mrst_out",   32'(res_out),   32'd0);
        chk("mrst_id",    32'(res_id),    32'd0);
        chk("mrst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        cycle(); chk("post_rst_g0", 32'(res_id), 32'd0);

        // Random phase. A requester keeps its valid and operands stable until
        // its handshake completes.
        for (int n = 0; n < 600; n++) begin
            res_ready = ($urandom_range(0, 3) != 0);
            cycle();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (last_g == i || !req_valid[i]) begin
                    set_req(i, ($urandom_range(0, 2) != 0), 4'($urandom), 4'($urandom));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul4s_rr_arbiter.md
Name: mul4s_rr_arbiter

Overview:
- Shares one combinational signed 4x4 exact multiplier core (4b x 4b two's complement -> 8b two's complement) among NUM_REQ requesters.
- Each requester has a valid/ready operand channel. A round-robin arbiter grants one request per cycle.
- The product leaves through a single registered result channel with valid/ready backpressure, tagged with the requester index.
- Sits between the multiplier core and the operand-producing blocks; the core itself is instantiated inside unchanged.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, 2, width of res_id; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  4*NUM_REQ  signed multiplicand, requester i at [4i+3:4i].
- req_b  in  4*NUM_REQ  signed multiplier, requester i at [4i+3:4i].
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accept.
- res_out  out  8  signed product, two's complement.
- res_id  out  ID_W  index of the requester that produced res_out.

Behaviour:
- Reset (rst=1 at a clock edge): res_valid=0, res_out=0, res_id=0, round-robin pointer ptr=0. req_ready is forced to all-zero while rst=1.
- Slot free: free = ~res_valid | res_ready.
- Grant:
  - Combinational search over req_valid starting at index ptr, wrapping modulo NUM_REQ.
  - The first valid index g gets req_ready[g] = free. All other req_ready bits are 0.
  - req_ready never depends on the same requester's own valid beyond this search; no combinational loop back to req_valid.
- Transfer: req_valid[g] & req_ready[g] at edge t, then at edge t:
  - res_out <= product(req_a[g], req_b[g])
  - res_id <= g
  - res_valid <= 1
  - ptr <= (g+1) mod NUM_REQ
- Latency and throughput: latency 1 cycle (accept at t, result visible after t); throughput 1 result per cycle when res_ready=1.
- No grant while free=1:
  - If res_ready & res_valid: res_valid <= 0. res_out and res_id hold their last values.
  - ptr is unchanged.
- Backpressure: res_valid=1 & res_ready=0 → res_out, res_id and res_valid hold; every req_ready is 0; ptr holds.
- Simultaneous drain and grant: the new result replaces the old one in the same edge; res_valid stays 1. No bubble and no loss.
- Fairness: a requester holding valid is granted within NUM_REQ successful grants.
- Requester protocol: once asserted, a requester's valid and operands stay stable until its handshake. The block does not check this.
- Arithmetic:
  - Full exact signed product, no saturation. Range -56..64.
  - -8 x -8 = +64 = 0x40 fits in 8b.
- Reset mid-operation: a pending result is discarded (res_valid=0), ptr returns to 0, and no handshake completes in that cycle.
- Indices g >= NUM_REQ never occur; res_id upper codes are unused.

Optional Feature:
- Macro MUL4S_ARB_PIPE_EN.
- Defined:
  - Adds an operand stage: stage 1 registers a, b, id and a valid bit; stage 2 is the existing result register, computed from stage 1.
  - free is then evaluated for stage 1: ~s1_valid | s1 advances, where s1 advances when ~res_valid | res_ready.
  - Latency is 2 cycles; throughput stays 1 per cycle.
  - Reset clears both valid bits and data.
  - ptr updates at the grant edge exactly as without the macro.
- Undefined: single-stage behaviour exactly as described above.

Test Plan:
- Single requester, res_ready=1: req0 a=0x8, b=0x8 → res_out=0x40, res_id=0 one cycle after the handshake (two with MUL4S_ARB_PIPE_EN). Then a=0x8, b=0x7 → 0xC8; a=0x7, b=0x7 → 0x31; a=0x3, b=0xF → 0xFD. Also sweep all 256 operand pairs against a signed reference.
- All 4 requesters valid continuously, res_ready=1 → grant order 0,1,2,3,0,1; exactly one req_ready high per cycle; res_valid high every cycle after the first.
- Only requesters 1 and 3 valid, ptr=2 → grant 3 then 1 then 3; requesters 0 and 2 never granted.
- Result pending, res_ready=0 for 3 cycles with req_valid=1111 → res_out/res_id stable, all req_ready=0. On the cycle res_ready=1, a new grant occurs and res_valid stays 1 with the new result next cycle.
- Drain with no requests: res_valid=1, res_ready=1, req_valid=0 → res_valid=0 next cycle; ptr unchanged.
- rst=1 asserted while res_valid=1 and req_valid=1111 → next cycle res_valid=0, res_out=0, res_id=0, req_ready=0. After release, the first grant goes to requester 0.
